// File: rtl/minesweeper_pkg.sv
// Shared types and constants for the Minesweeper board-setup logic.
// Holds the placer state encoding and the 16-bit LFSR definition.
package minesweeper_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    CHECK,
    WRITE,
    INC,
    DONE
  } state_t;

  localparam int CELL_WIDTH = 8;

  // The mine flag sits in the top bit of a cell; counts live below it.
  function automatic int mine_bit(input int bus_width);
    return bus_width - 1;
  endfunction

  localparam int MINE_BIT = mine_bit(CELL_WIDTH);

  // Taps for x^16+x^15+x^13+x^4+1 in Fibonacci form (bits 15,14,12,3).
  localparam logic [15:0] LFSR_TAPS  = 16'hD008;
  localparam logic [15:0] LFSR_RESET = 16'h0001;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit maximal-length Fibonacci LFSR with synchronous load and step enable.
// Load wins over step; the register never holds zero when loaded through the placer.
module lfsr16
  import minesweeper_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        step,
  output logic [15:0] value
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= LFSR_RESET;
    end else if (load) begin
      value <= load_value;
    end else if (step) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/mine_placer.sv
// Places a requested number of mines at pseudo-random, distinct board cells,
// keeping the first-click cell clear. Drives the board's read, write and increment ports.
module mine_placer
  import minesweeper_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int HEIGHT    = 8,
  parameter int BUS_WIDTH = CELL_WIDTH,
  parameter int XW        = $clog2(WIDTH),
  parameter int YW        = $clog2(HEIGHT),
  parameter int NW        = $clog2(WIDTH * HEIGHT + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [15:0]          seed,
  input  logic [NW-1:0]        num_mines,
  input  logic [XW-1:0]        avoid_x,
  input  logic [YW-1:0]        avoid_y,
  output logic [XW-1:0]        read_x,
  output logic [YW-1:0]        read_y,
  input  logic [BUS_WIDTH-1:0] read_value,
  output logic                 write_en,
  output logic [XW-1:0]        write_x,
  output logic [YW-1:0]        write_y,
  output logic [BUS_WIDTH-1:0] write_value,
  output logic                 inc_adjacent,
  output logic                 busy,
  output logic                 done,
  output logic [NW-1:0]        placed_count
);

  localparam int                   FLAG       = mine_bit(BUS_WIDTH);
  localparam logic [BUS_WIDTH-1:0] MINE_MASK  = BUS_WIDTH'(1) << FLAG;
  localparam logic [NW-1:0]        MAX_MINES  = NW'(WIDTH * HEIGHT - 1);
  localparam logic [XW:0]          WIDTH_LIM  = (XW + 1)'(WIDTH);
  localparam logic [YW:0]          HEIGHT_LIM = (YW + 1)'(HEIGHT);

  state_t          state, state_next;
  logic [15:0]     lfsr_value;
  logic [15:0]     lfsr_peek;
  logic [15:0]     lfsr_load_value;
  logic [XW-1:0]   cand_x, avoid_x_q;
  logic [YW-1:0]   cand_y, avoid_y_q;
  logic [NW-1:0]   target;
  logic [NW-1:0]   clamped_mines;
  logic            accept_start;
  logic            reject;
  logic            last_mine;
  logic            unused_lfsr_bits;

  assign accept_start    = (state == IDLE) && start;
  assign clamped_mines   = (num_mines > MAX_MINES) ? MAX_MINES : num_mines;
  assign lfsr_load_value = (seed == 16'h0000) ? LFSR_RESET : seed;
  assign lfsr_peek       = lfsr_next(lfsr_value);
  assign last_mine       = (placed_count + NW'(1)) == target;

  // Only the low XW+YW bits form a candidate; the rest just keep the sequence long.
  assign unused_lfsr_bits = ^lfsr_peek[15:XW+YW];

  assign reject = ({1'b0, cand_x} >= WIDTH_LIM)  ||
                  ({1'b0, cand_y} >= HEIGHT_LIM) ||
                  ((cand_x == avoid_x_q) && (cand_y == avoid_y_q)) ||
                  read_value[FLAG];

  assign read_x  = cand_x;
  assign read_y  = cand_y;
  assign write_x = cand_x;
  assign write_y = cand_y;

  lfsr16 u_lfsr (
    .clk       (clk),
    .reset     (reset),
    .load      (accept_start),
    .load_value(lfsr_load_value),
    .step      (state == GEN),
    .value     (lfsr_value)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (clamped_mines == '0) ? DONE : GEN;
        end
      end
      GEN:     state_next = CHECK;
      CHECK:   state_next = reject ? GEN : WRITE;
      WRITE:   state_next = INC;
      INC:     state_next = last_mine ? DONE : GEN;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes are decoded from state alone, so WRITE and INC can never overlap
  // and an asserted reset drops them in the same cycle.
  always_comb begin
    write_en     = 1'b0;
    inc_adjacent = 1'b0;
    done         = 1'b0;
    busy         = 1'b1;
    case (state)
      IDLE:    busy         = 1'b0;
      WRITE:   write_en     = 1'b1;
      INC:     inc_adjacent = 1'b1;
      DONE:    done         = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand_x       <= '0;
      cand_y       <= '0;
      avoid_x_q    <= '0;
      avoid_y_q    <= '0;
      target       <= '0;
      placed_count <= '0;
      write_value  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            target       <= clamped_mines;
            placed_count <= '0;
            avoid_x_q    <= avoid_x;
            avoid_y_q    <= avoid_y;
          end
        end
        GEN: begin
          cand_x <= lfsr_peek[XW-1:0];
          cand_y <= lfsr_peek[XW+YW-1:XW];
        end
        CHECK: begin
          // Keep whatever neighbour count the cell already accumulated.
          if (!reject) begin
            write_value <= read_value | MINE_MASK;
          end
        end
        INC:     placed_count <= placed_count + NW'(1);
        default: ;
      endcase
    end
  end

endmodule
